// File: rtl/sm_register_c_we.sv
// sm_register_c_we: SIZE-bit D-register, async active-low clear to RST_VAL,
// optional sync write enable (USE_WE=1 gates on we; USE_WE=0 loads every clk).
// Ports: clk, rst_n, we (load enable), d [SIZE-1:0], q [SIZE-1:0] (flop output).
module sm_register_c_we #(
    parameter int unsigned     SIZE    = 32,
    parameter bit              USE_WE  = 1'b1,
    parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [SIZE-1:0] d,
    output logic [SIZE-1:0] q
);

    logic            load;
    // Declaration value gives a deterministic start in simulation only.
    logic [SIZE-1:0] q_r = RST_VAL;

    // With USE_WE=0 the enable is forced high so we has no effect.
    assign load = we | ~USE_WE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= RST_VAL;
        end else if (load) begin
            q_r <= d;
        end
    end

    assign q = q_r;

endmodule

// File: tb/tb_sm_register_c_we.sv
// tb_sm_register_c_we: table vectors, directed corner cases and random
// stimulus against a behavioural model for four register configurations.
module tb_sm_register_c_we;

    logic        clk;
    logic        rst_n;
    logic        we32, we1, we8c, we8z;
    logic [31:0] d32, q32;
    logic [0:0]  d1, q1;
    logic [7:0]  d8c, q8c, d8z, q8z;

    int checks   = 0;
    int failures = 0;

    sm_register_c_we #(.SIZE(32), .USE_WE(1'b1), .RST_VAL(32'h0)) u32 (
        .clk(clk), .rst_n(rst_n), .we(we32), .d(d32), .q(q32)
    );
    sm_register_c_we #(.SIZE(1), .USE_WE(1'b0), .RST_VAL(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .we(we1), .d(d1), .q(q1)
    );
    sm_register_c_we #(.SIZE(8), .USE_WE(1'b1), .RST_VAL(8'h3C)) u8c (
        .clk(clk), .rst_n(rst_n), .we(we8c), .d(d8c), .q(q8c)
    );
    sm_register_c_we #(.SIZE(8), .USE_WE(1'b1), .RST_VAL(8'h00)) u8z (
        .clk(clk), .rst_n(rst_n), .we(we8z), .d(d8z), .q(q8z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t t32[7];
    vec_t t1[5];

    logic [31:0] e32;
    logic        e1;
    logic [7:0]  e8c, e8z;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        t32[0] = '{1'b1, 32'h1000_0004, 32'h1000_0004};
        t32[1] = '{1'b0, 32'hFFFF_FFFF, 32'h1000_0004};
        t32[2] = '{1'b0, 32'hFFFF_FFFF, 32'h1000_0004};
        t32[3] = '{1'b0, 32'hFFFF_FFFF, 32'h1000_0004};
        t32[4] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        t32[5] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF};
        t32[6] = '{1'b1, 32'h0000_0000, 32'h0000_0000};
        t1[0]  = '{1'b0, 32'd1, 32'd1};
        t1[1]  = '{1'b0, 32'd0, 32'd0};
        t1[2]  = '{1'b0, 32'd1, 32'd1};
        t1[3]  = '{1'b0, 32'd1, 32'd1};
        t1[4]  = '{1'b0, 32'd0, 32'd0};

        rst_n = 1'b1;
        we32 = 0; we1 = 0; we8c = 0; we8z = 0;
        d32 = 0; d1 = 0; d8c = 0; d8z = 0;

        // Deterministic start value before any reset or clock edge.
        #1;
        check("init_q32", q32, 32'h0);
        check("init_q8c", {24'h0, q8c}, 32'h3C);

        // Load, then assert reset between edges.
        we32 = 1; d32 = 32'hDEAD_BEEF;
        we8c = 1; d8c = 8'hFF;
        repeat (3) tick();
        check("load_q32", q32, 32'hDEAD_BEEF);
        check("load_q8c", {24'h0, q8c}, 32'hFF);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_q32", q32, 32'h0);
        check("async_rst_q8c", {24'h0, q8c}, 32'h3C);
        check("async_rst_q1", {31'h0, q1}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            we32 = 1; d32 = $urandom;
            we8c = 1; d8c = 8'($urandom);
            d1 = 1'($urandom);
            tick();
            check($sformatf("rst_hold_q32[%0d]", i), q32, 32'h0);
            check($sformatf("rst_hold_q8c[%0d]", i), {24'h0, q8c}, 32'h3C);
        end

        // Release between edges with a load pending.
        we8z = 1; d8z = 8'hA5;
        #2 rst_n = 1'b1;
        #1;
        check("release_pre", {24'h0, q8z}, 32'h0);
        tick();
        check("release_load", {24'h0, q8z}, 32'hA5);
        we8z = 0;

        // Enabled-load table on the 32-bit register.
        for (int i = 0; i < 7; i++) begin
            we32 = t32[i].we;
            d32  = t32[i].d;
            tick();
            check($sformatf("tbl32[%0d]", i), q32, t32[i].exp);
        end

        // Always-load 1-bit register, enable held low.
        for (int i = 0; i < 5; i++) begin
            we1 = t1[i].we;
            d1  = t1[i].d[0:0];
            tick();
            check($sformatf("tbl1[%0d]", i), {31'h0, q1}, t1[i].exp);
        end

        // Back-to-back loads with a counting input.
        for (int i = 0; i < 16; i++) begin
            we32 = 1; d32 = 32'(i);
            tick();
            check($sformatf("count[%0d]", i), q32, 32'(i));
        end

        // Random phase from a known reset state.
        #2 rst_n = 1'b0;
        e32 = 0; e1 = 0; e8c = 8'h3C; e8z = 8'h00;
        tick();
        for (int n = 0; n < 300; n++) begin
            we32 = 1'($urandom); d32 = $urandom;
            we1  = 1'($urandom); d1  = 1'($urandom);
            we8c = 1'($urandom); d8c = 8'($urandom);
            we8z = 1'($urandom); d8z = 8'($urandom);
            if (!rst_n && ($urandom % 4 == 0)) begin
                #2 rst_n = 1'b1;
            end else if (rst_n && ($urandom % 20 == 0)) begin
                #2 rst_n = 1'b0;
                e32 = 0; e1 = 0; e8c = 8'h3C; e8z = 8'h00;
                #1;
                check("rand_async_q32", q32, e32);
                check("rand_async_q8c", {24'h0, q8c}, {24'h0, e8c});
            end
            tick();
            if (!rst_n) begin
                e32 = 0; e1 = 0; e8c = 8'h3C; e8z = 8'h00;
            end else begin
                if (we32) e32 = d32;
                e1 = d1[0];
                if (we8c) e8c = d8c;
                if (we8z) e8z = d8z;
            end
            check("rand_q32", q32, e32);
            check("rand_q1", {31'h0, q1}, {31'h0, e1});
            check("rand_q8c", {24'h0, q8c}, {24'h0, e8c});
            check("rand_q8z", {24'h0, q8z}, {24'h0, e8z});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
